// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if: push port, status flags and UART handshake of the transmit feeder.
interface uart_tx_feeder_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    wdata;
  logic          wen;
  logic          clr_err;
  logic          txready;
  logic [7:0]    txdata;
  logic          txclk;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          busy;
  logic          err;
  logic          overflow;

  // User logic and the UART side drive the inputs and observe the status.
  modport master (
    output wdata, wen, clr_err, txready,
    input  txdata, txclk, count, full, empty, busy, err, overflow
  );

  // The feeder itself.
  modport slave (
    input  wdata, wen, clr_err, txready,
    output txdata, txclk, count, full, empty, busy, err, overflow
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers pushed bytes in a small FIFO and hands them to the
// board UART one at a time over the txdata/txclk/txready handshake.
module uart_tx_feeder #(
  parameter int DEPTH         = 8,
  parameter int STROBE_CYCLES = 4,
  parameter int TIMEOUT       = 4096
) (
  input  logic            hwclk,
  input  logic            reset_n,
  uart_tx_feeder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STROBE_CYCLES);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT_ACK,
    WAIT_DONE
  } state_e;

  state_e        state_q, state_d;

  logic          rdy_p0;
  logic          rdy_s;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  logic [7:0]    txdata_q, txdata_d;
  logic          txclk_q, txclk_d;
  logic [SW-1:0] strb_q, strb_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          acked_q, acked_d;
  logic          busy_q;
  logic          err_set;
  logic          err_q;
  logic          ovf_q;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A push is only refused when the FIFO is full and nothing leaves this cycle.
  assign push  = bus.wen && (!full || pop);

  // txready lives in the serial-clock domain; reset treats the UART as busy.
  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_p0 <= 1'b0;
      rdy_s  <= 1'b0;
    end else begin
      rdy_p0 <= bus.txready;
      rdy_s  <= rdy_p0;
    end
  end

  // FIFO storage carries data only, so it has no reset.
  always_ff @(posedge hwclk) begin
    if (push) begin
      mem[wr_ptr] <= bus.wdata;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop keeps the count.
  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Handshake FSM: next state, strobe/timeout counters and the single pop per byte.
  always_comb begin
    state_d  = state_q;
    txdata_d = txdata_q;
    txclk_d  = txclk_q;
    strb_d   = strb_q;
    tmo_d    = tmo_q;
    acked_d  = acked_q;
    pop      = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && rdy_s) begin
          txdata_d = mem[rd_ptr];
          txclk_d  = 1'b1;
          strb_d   = SW'(STROBE_CYCLES - 1);
          acked_d  = 1'b0;
          state_d  = STROBE;
        end
      end
      STROBE: begin
        // The UART may accept before the strobe ends; pop once and remember it.
        if (!rdy_s && !acked_q) begin
          pop     = 1'b1;
          acked_d = 1'b1;
        end
        if (strb_q == '0) begin
          txclk_d = 1'b0;
          tmo_d   = '0;
          state_d = (acked_q || !rdy_s) ? WAIT_DONE : WAIT_ACK;
        end else begin
          strb_d = strb_q - SW'(1);
        end
      end
      WAIT_ACK: begin
        if (!rdy_s) begin
          pop     = 1'b1;
          state_d = WAIT_DONE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // Never accepted: discard the byte so the queue keeps moving.
          pop     = 1'b1;
          err_set = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (rdy_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and registered handshake outputs; busy tracks the next state.
  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      txdata_q <= '0;
      txclk_q  <= 1'b0;
      strb_q   <= '0;
      tmo_q    <= '0;
      acked_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      txdata_q <= txdata_d;
      txclk_q  <= txclk_d;
      strb_q   <= strb_d;
      tmo_q    <= tmo_d;
      acked_q  <= acked_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  // Sticky error flags; a clear wins over a set in the same cycle.
  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (bus.clr_err) begin
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      err_q <= err_q | err_set;
      ovf_q <= ovf_q | (bus.wen && !push);
    end
  end

  assign bus.txdata   = txdata_q;
  assign bus.txclk    = txclk_q;
  assign bus.count    = count_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;
  assign bus.overflow = ovf_q;

endmodule
